// File: rtl/mem_arbiter.sv
// Bounded-burst round-robin arbiter sharing one 256x8 RAM between the CPU
// datapath and the host loader/debug port, with registered read return.
module mem_arbiter #(
    parameter int unsigned MAX_BURST  = 4,
    parameter bit          HOST_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,

    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_stall,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,

    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic [7:0] host_rdata,
    output logic       host_rvalid,

    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,

    output logic [7:0] conflict_cnt
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0] owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       both_req;
    logic       burst_done;
    logic       gnt_cpu, gnt_host;

    logic [7:0] cpu_rdata_q, host_rdata_q;
    logic       cpu_rvalid_q, host_rvalid_q;
    logic [7:0] conflict_q;

    assign both_req   = cpu_req & host_req;
    assign burst_done = (cnt_q >= BURST_MAX);
    assign cnt_inc    = burst_done ? BURST_MAX : cnt_q + 4'd1;

    // Grants are held low during reset so nothing reaches the RAM.
    always_comb begin
        gnt_cpu  = 1'b0;
        gnt_host = 1'b0;
        if (reset_n) begin
            if (both_req) begin
                case (owner_q)
                    OWN_CPU: begin
                        gnt_cpu  = ~burst_done;
                        gnt_host = burst_done;
                    end
                    OWN_HOST: begin
                        gnt_host = ~burst_done;
                        gnt_cpu  = burst_done;
                    end
                    default: begin
                        gnt_host = HOST_FIRST;
                        gnt_cpu  = ~HOST_FIRST;
                    end
                endcase
            end else begin
                gnt_cpu  = cpu_req;
                gnt_host = host_req;
            end
        end
    end

    assign cpu_gnt   = gnt_cpu;
    assign host_gnt  = gnt_host;
    assign cpu_stall = cpu_req & ~gnt_cpu;

    always_comb begin
        mem_addr  = 8'h00;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (gnt_cpu) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (gnt_host) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        cnt_d   = 4'd0;
        if (gnt_cpu) begin
            owner_d = OWN_CPU;
            cnt_d   = (owner_q == OWN_CPU) ? cnt_inc : 4'd1;
        end else if (gnt_host) begin
            owner_d = OWN_HOST;
            cnt_d   = (owner_q == OWN_HOST) ? cnt_inc : 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
            cnt_q   <= 4'd0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data returns one cycle after the grant; rdata holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_q   <= 8'h00;
            cpu_rvalid_q  <= 1'b0;
            host_rdata_q  <= 8'h00;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= gnt_cpu & ~cpu_we;
            host_rvalid_q <= gnt_host & ~host_we;
            if (gnt_cpu && !cpu_we) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (gnt_host && !host_we) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= 8'h00;
        end else if (both_req && conflict_q != 8'hFF) begin
            conflict_q <= conflict_q + 8'd1;
        end
    end

    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rvalid   = cpu_rvalid_q;
    assign host_rdata   = host_rdata_q;
    assign host_rvalid  = host_rvalid_q;
    assign conflict_cnt = conflict_q;

endmodule
